rom_fuse_programmer: RTL and testbench

//  Write-side counterpart of the IP3601/IP3604 reader path: burns one PROM word at a time.

---
 rtl/rom_prog_pkg.sv | 41 ++++
 rtl/rom_prog_timer.sv | 42 ++++
 rtl/rom_fuse_programmer.sv | 217 +++++++++++++++++++++
 tb/tb_rom_fuse_programmer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_prog_pkg.sv
// Shared definitions for the PROM fuse programmer: state encoding,
// default timing constants and the IP3601/IP3604 geometry.
package rom_prog_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_READ    = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_PULSE   = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_FAIL    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SETUP   = ST_SETUP,
        S_READ    = ST_READ,
        S_CHECK   = ST_CHECK,
        S_PULSE   = ST_PULSE,
        S_RECOVER = ST_RECOVER,
        S_DONE    = ST_DONE,
        S_FAIL    = ST_FAIL
    } prog_state_e;

    localparam int DEF_SETUP_CYCLES    = 16;
    localparam int DEF_PULSE_CYCLES    = 500;
    localparam int DEF_RECOVERY_CYCLES = 100;
    localparam int DEF_MAX_ATTEMPTS    = 8;

    localparam int IP3601_DATA_WIDTH    = 4;
    localparam int IP3601_ADDRESS_WIDTH = 8;
    localparam int IP3604_DATA_WIDTH    = 8;
    localparam int IP3604_ADDRESS_WIDTH = 9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rom_prog_timer.sv
// Loadable down-counter for the programmer's timed states. Loading N-1
// makes the owning state last exactly N cycles; 'loaded' marks the first.
module rom_prog_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired,
    output logic             loaded
);

    logic [WIDTH-1:0] count_r;
    logic             loaded_r;

    // Count down to zero, restarting whenever a new value is loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // One-cycle strobe marking the first cycle of a freshly loaded period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loaded_r <= 1'b0;
        end else begin
            loaded_r <= load;
        end
    end

    assign expired = (count_r == {WIDTH{1'b0}});
    assign loaded  = loaded_r;

endmodule

// File: rtl/rom_fuse_programmer.sv
// PROM fuse-programming sequencer: reads the cell, pulses each blank
// target bit (lowest first) and re-reads after every pulse.
// Optional macro ROM_PROG_OVERPULSE_EN: one extra margin pulse after each
// bit first reads back programmed (not counted as an attempt).
module rom_fuse_programmer
    import rom_prog_pkg::*;
#(
    parameter int DATA_WIDTH      = IP3604_DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = IP3604_ADDRESS_WIDTH,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
    parameter int MAX_ATTEMPTS    = DEF_MAX_ATTEMPTS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic                     chip_select_n,
    output logic [DATA_WIDTH-1:0]    prog_bit_line,
    output logic                     prog_pulse,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    fail_mask
);

    localparam int TIMER_RAW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, RECOVERY_CYCLES) + 1);
    localparam int TIMER_W   = (TIMER_RAW < 2) ? 2 : TIMER_RAW;
    localparam logic [3:0] MAX_ATT = 4'(MAX_ATTEMPTS);

    // Isolate the lowest set bit (two's-complement trick).
    function automatic logic [DATA_WIDTH-1:0] lowest_bit(input logic [DATA_WIDTH-1:0] v);
        lowest_bit = v & (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1});
    endfunction

    prog_state_e state_r, state_s;
    logic [ADDRESS_WIDTH-1:0] address_r;
    logic [DATA_WIDTH-1:0] target_r, rb_r, sel_r, sel_s, fail_mask_r, fail_mask_s, prog_bit_r;
    logic [DATA_WIDTH-1:0] bad_s, low_s;
    logic [3:0] attempts_r, attempts_s;
    logic error_r, done_r, busy_r, cs_n_r, prog_pulse_r;
    logic load_s, expired_s, loaded_s, over_due_s, over_active_s;
    logic [TIMER_W-1:0] load_value_s;

    assign bad_s = rb_r & ~target_r;
    assign low_s = lowest_bit(target_r & ~rb_r);

`ifdef ROM_PROG_OVERPULSE_EN
    logic pulsed_r, over_r;

    // Remember whether the selected bit has had a counted pulse and its margin pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulsed_r <= 1'b0;
            over_r   <= 1'b0;
        end else if (state_r == S_IDLE && start) begin
            pulsed_r <= 1'b0;
            over_r   <= 1'b0;
        end else if (state_r == S_CHECK && state_s == S_PULSE) begin
            if (over_due_s) begin
                over_r <= 1'b1;
            end else begin
                pulsed_r <= 1'b1;
                over_r   <= 1'b0;
            end
        end else begin
            pulsed_r <= pulsed_r;
            over_r   <= over_r;
        end
    end

    assign over_due_s    = pulsed_r && !over_r && (|(rb_r & sel_r));
    assign over_active_s = over_r;
`else
    assign over_due_s    = 1'b0;
    assign over_active_s = 1'b0;
`endif

    // Next-state, bit selection, attempt counting and failure mask.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        attempts_s  = attempts_r;
        fail_mask_s = fail_mask_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s     = S_SETUP;
                    sel_s       = {DATA_WIDTH{1'b0}};
                    attempts_s  = 4'd0;
                    fail_mask_s = {DATA_WIDTH{1'b0}};
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETUP: begin
                if (expired_s) state_s = S_READ;
                else           state_s = S_SETUP;
            end
            S_READ: state_s = S_CHECK;
            S_CHECK: begin
                if (bad_s != {DATA_WIDTH{1'b0}}) begin
                    state_s     = S_FAIL;
                    fail_mask_s = bad_s;
                end else if (over_due_s) begin
                    state_s = S_PULSE;
                end else if (rb_r == target_r) begin
                    state_s = S_DONE;
                end else begin
                    sel_s = low_s;
                    if (low_s != sel_r) attempts_s = 4'd0;
                    else                attempts_s = attempts_r;
                    if (attempts_s == MAX_ATT) begin
                        state_s     = S_FAIL;
                        fail_mask_s = low_s;
                    end else begin
                        state_s = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (loaded_s && !over_active_s) attempts_s = attempts_r + 4'd1;
                else                            attempts_s = attempts_r;
                if (expired_s) state_s = S_RECOVER;
                else           state_s = S_PULSE;
            end
            S_RECOVER: begin
                if (expired_s) state_s = S_READ;
                else           state_s = S_RECOVER;
            end
            S_DONE:  state_s = S_IDLE;
            S_FAIL:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Load the timer on entry to each timed state.
    always_comb begin
        load_s       = 1'b0;
        load_value_s = {TIMER_W{1'b0}};
        if (state_s != state_r) begin
            case (state_s)
                S_SETUP:   begin load_s = 1'b1; load_value_s = TIMER_W'(SETUP_CYCLES - 1);    end
                S_PULSE:   begin load_s = 1'b1; load_value_s = TIMER_W'(PULSE_CYCLES - 1);    end
                S_RECOVER: begin load_s = 1'b1; load_value_s = TIMER_W'(RECOVERY_CYCLES - 1); end
                default:   begin load_s = 1'b0; load_value_s = {TIMER_W{1'b0}};               end
            endcase
        end else begin
            load_s       = 1'b0;
            load_value_s = {TIMER_W{1'b0}};
        end
    end

    rom_prog_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_s),
        .load_value (load_value_s),
        .expired    (expired_s),
        .loaded     (loaded_s)
    );

    // State, working registers and registered pin/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            address_r    <= {ADDRESS_WIDTH{1'b0}};
            target_r     <= {DATA_WIDTH{1'b0}};
            rb_r         <= {DATA_WIDTH{1'b0}};
            sel_r        <= {DATA_WIDTH{1'b0}};
            attempts_r   <= 4'd0;
            fail_mask_r  <= {DATA_WIDTH{1'b0}};
            prog_bit_r   <= {DATA_WIDTH{1'b0}};
            error_r      <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            cs_n_r       <= 1'b1;
            prog_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            attempts_r   <= attempts_s;
            fail_mask_r  <= fail_mask_s;
            busy_r       <= (state_s != S_IDLE);
            done_r       <= (state_s == S_DONE) || (state_s == S_FAIL);
            cs_n_r       <= !((state_s == S_SETUP) || (state_s == S_READ) || (state_s == S_CHECK) ||
                              (state_s == S_PULSE) || (state_s == S_RECOVER));
            prog_pulse_r <= (state_s == S_PULSE);
            prog_bit_r   <= (state_s == S_PULSE) ? sel_s : {DATA_WIDTH{1'b0}};
            if (state_r == S_IDLE && start) begin
                address_r <= address_in;
                target_r  <= data_in;
                error_r   <= 1'b0;
            end else if (state_s == S_FAIL) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
            if (state_r == S_READ) rb_r <= data_line_in;
            else                   rb_r <= rb_r;
        end
    end

    assign address_line  = address_r;
    assign chip_select_n = cs_n_r;
    assign prog_bit_line = prog_bit_r;
    assign prog_pulse    = prog_pulse_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign fail_mask     = fail_mask_r;

endmodule

// File: tb/tb_rom_fuse_programmer.sv
// Randomized scoreboard bench for rom_fuse_programmer with a behavioural
// fuse-cell model (each bit burns after a configurable number of pulses).
module tb_rom_fuse_programmer;

    localparam int DW = 8, AW = 9, SETUP = 2, PULSE = 4, REC = 3, MAXA = 3;

    logic clk = 1'b0, reset_n = 1'b1, start = 1'b0;
    logic [AW-1:0] address_in = '0;
    logic [DW-1:0] data_in = '0, data_line_in;
    logic [AW-1:0] address_line;
    logic chip_select_n, prog_pulse, busy, done, error;
    logic [DW-1:0] prog_bit_line, fail_mask;

    rom_fuse_programmer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SETUP_CYCLES(SETUP),
        .PULSE_CYCLES(PULSE), .RECOVERY_CYCLES(REC), .MAX_ATTEMPTS(MAXA)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .address_in(address_in),
        .data_in(data_in), .data_line_in(data_line_in), .address_line(address_line),
        .chip_select_n(chip_select_n), .prog_bit_line(prog_bit_line), .prog_pulse(prog_pulse),
        .busy(busy), .done(done), .error(error), .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- fuse cell model ----------------
    logic [DW-1:0] fuse = '0, cfg_word = '0, cur_bit = '0;
    int remaining[DW];
    int cfg_need[DW];
    bit cfg_req = 1'b0, cfg_seen = 1'b0;
    int plen = 0, pulses_total = 0;

    assign data_line_in = chip_select_n ? '0 : fuse;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plen = 0;
        end else begin
            if (cfg_req != cfg_seen) begin
                fuse = cfg_word;
                for (int i = 0; i < DW; i++) remaining[i] = cfg_need[i];
                cfg_seen = cfg_req;
            end
            if (prog_pulse) begin
                chk("pulse_onehot", $countones(prog_bit_line), 1);
                chk("pulse_cs", chip_select_n, 0);
                plen = plen + 1;
                cur_bit = prog_bit_line;
            end else if (plen != 0) begin
                chk("pulse_len", plen, PULSE);
                pulses_total = pulses_total + 1;
                for (int i = 0; i < DW; i++) begin
                    if (cur_bit[i]) begin
                        remaining[i] = remaining[i] - 1;
                        if (remaining[i] <= 0) fuse[i] = 1'b1;
                    end
                end
                plen = 0;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic          err;
        logic [DW-1:0] mask;
        int            pulses;
        logic [DW-1:0] final_word;
        int            latency;
        logic [AW-1:0] addr;
        int            start_cyc;
        int            pulse_base;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic exp_t ref_model(input logic [DW-1:0] w, input logic [DW-1:0] t, input int need[DW]);
        exp_t r;
        bit stop;
        logic [DW-1:0] one;
        r.err = 1'b0; r.mask = '0; r.pulses = 0; r.final_word = w;
        r.addr = '0; r.start_cyc = 0; r.pulse_base = 0;
        stop = 1'b0;
        one = 1;
        if ((w & ~t) != '0) begin
            r.err  = 1'b1;
            r.mask = w & ~t;
        end else begin
            for (int i = 0; i < DW; i++) begin
                if (!stop && t[i] && !w[i]) begin
                    if (need[i] <= MAXA) begin
                        r.pulses += need[i];
                        r.final_word[i] = 1'b1;
`ifdef ROM_PROG_OVERPULSE_EN
                        r.pulses += 1;
`endif
                    end else begin
                        r.err    = 1'b1;
                        r.mask   = one << i;
                        r.pulses += MAXA;
                        stop     = 1'b1;
                    end
                end
            end
        end
        r.latency = SETUP + 2 + r.pulses * (PULSE + REC + 2);
        return r;
    endfunction

    // Monitor: every done strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("error", error, mon_e.err);
                if (mon_e.err) chk("fail_mask", fail_mask, mon_e.mask);
                chk("pulse_count", pulses_total - mon_e.pulse_base, mon_e.pulses);
                chk("final_word", fuse, mon_e.final_word);
                chk("latency", cyc - mon_e.start_cyc, mon_e.latency);
                chk("address_line", address_line, mon_e.addr);
                chk("busy_at_done", busy, 1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic load_cell(input logic [DW-1:0] w);
        cfg_word = w;
        cfg_req  = ~cfg_req;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_need(input int v);
        for (int i = 0; i < DW; i++) cfg_need[i] = v;
    endtask

    task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] w,
                           input logic [DW-1:0] t, input bit hold);
        exp_t e;
        int k;
        load_cell(w);
        address_in = a;
        data_in    = t;
        start      = 1'b1;
        @(posedge clk);
        #1;
        e            = ref_model(w, t, cfg_need);
        e.addr       = a;
        e.start_cyc  = cyc;
        e.pulse_base = pulses_total;
        sb.push_back(e);
        if (!hold) start = 1'b0;
        address_in = AW'($urandom);
        data_in    = DW'($urandom);
        k = 0;
        @(negedge clk);
        while (!done && k < 4000) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (k >= 4000) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("idle_after_done", busy, 0);
        chk("error_held", error, e.err);
    endtask

    initial begin
        int k;
        logic [DW-1:0] w, t;
        set_need(1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_fail_mask", fail_mask, 0);
        chk("rst_prog_pulse", prog_pulse, 0);
        chk("rst_prog_bit", prog_bit_line, 0);
        chk("rst_cs_n", chip_select_n, 1);
        chk("rst_address", address_line, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Blank cell, bits burn after one pulse.
        set_need(1);
        run_txn(9'h012, 8'h00, 8'h05, 1'b0);
        // Already programmed.
        run_txn(9'h1a3, 8'h05, 8'h05, 1'b0);
        // Unexpected programmed bit.
        run_txn(9'h0ff, 8'h81, 8'h01, 1'b0);
        // Bit3 never burns.
        set_need(1);
        cfg_need[3] = 99;
        run_txn(9'h100, 8'h00, 8'h08, 1'b0);
        // start held high through the whole operation.
        set_need(2);
        run_txn(9'h055, 8'h00, 8'h30, 1'b1);

        // Reset in the middle of a pulse.
        set_need(1);
        load_cell(8'h00);
        address_in = 9'h077;
        data_in    = 8'h01;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!prog_pulse && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("pulse_seen", prog_pulse, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_prog_pulse", prog_pulse, 0);
        chk("midrst_prog_bit", prog_bit_line, 0);
        chk("midrst_cs_n", chip_select_n, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_txn(9'h077, 8'h00, 8'h01, 1'b0);

        // Randomized cells, targets and burn behaviour.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < DW; i++) cfg_need[i] = $urandom_range(1, 4);
            w = DW'($urandom);
            if ($urandom_range(0, 3) != 0) t = w | DW'($urandom);
            else                           t = DW'($urandom);
            run_txn(AW'($urandom), w, t, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
